// File: rtl/video_timing_scaler_pkg.sv
// Shared raster constants, RGB field layout and helpers for the timing/scaler block.
package video_timing_scaler_pkg;

    // 640x480@60 raster defaults
    localparam int unsigned VT_H_ACTIVE = 640;
    localparam int unsigned VT_H_FP     = 16;
    localparam int unsigned VT_H_SYNC   = 96;
    localparam int unsigned VT_H_BP     = 48;
    localparam int unsigned VT_V_ACTIVE = 480;
    localparam int unsigned VT_V_FP     = 10;
    localparam int unsigned VT_V_SYNC   = 2;
    localparam int unsigned VT_V_BP     = 33;

    // Centred 256x192 source window, scaled 2x
    localparam int unsigned VT_WIN_X0   = 64;
    localparam int unsigned VT_WIN_Y0   = 48;
    localparam int unsigned VT_SRC_W    = 256;
    localparam int unsigned VT_SRC_H    = 192;

    localparam int unsigned CNT_W       = 10;
    localparam int unsigned CNT_MAX     = 1024;
    localparam int unsigned SRC_CW      = 8;
    localparam int unsigned COLOR_W     = 8;
    localparam int unsigned RGB_W       = 3 * COLOR_W;

    // {r,g,b} bit-field slices of a 24-bit colour word
    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    // Per-pixel raster flags carried alongside the source fetch
    typedef struct packed {
        logic active;
        logic win;
        logic hs;
        logic vs;
    } vflags_t;

    localparam int unsigned VFLAGS_W = $bits(vflags_t);

    // True when lo <= v < lo+len
    function automatic logic in_range(input logic [CNT_W-1:0] v,
                                      input int unsigned lo,
                                      input int unsigned len);
        return (32'(v) >= lo) && (32'(v) < (lo + len));
    endfunction

endpackage

// File: rtl/video_timing_scaler_sig_delay.sv
// N-stage synchronous shift register with synchronous active-low clear.
module video_timing_scaler_sig_delay #(
    parameter int unsigned W = 1,
    parameter int unsigned N = 1
) (
    input  logic         pixclk,
    input  logic         reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [N];

    // Shift one stage per clock; reset flushes every stage
    always_ff @(posedge pixclk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < N; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[N-1];

endmodule

// File: rtl/video_timing_scaler.sv
// Raster timing generator with centred 2x-scaled source window and border colour.
module video_timing_scaler
    import video_timing_scaler_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = VT_H_ACTIVE,
    parameter int unsigned H_FP          = VT_H_FP,
    parameter int unsigned H_SYNC        = VT_H_SYNC,
    parameter int unsigned H_BP          = VT_H_BP,
    parameter int unsigned V_ACTIVE      = VT_V_ACTIVE,
    parameter int unsigned V_FP          = VT_V_FP,
    parameter int unsigned V_SYNC        = VT_V_SYNC,
    parameter int unsigned V_BP          = VT_V_BP,
    parameter int unsigned SYNC_ACT_HIGH = 0,
    parameter int unsigned WIN_X0        = VT_WIN_X0,
    parameter int unsigned WIN_Y0        = VT_WIN_Y0,
    parameter int unsigned SRC_W         = VT_SRC_W,
    parameter int unsigned SRC_H         = VT_SRC_H,
    parameter int unsigned PIX_LAT       = 2
) (
    input  logic               pixclk,
    input  logic               reset_n,
    input  logic [RGB_W-1:0]   border_rgb,
    input  logic [RGB_W-1:0]   src_rgb,
    output logic               src_req,
    output logic [SRC_CW-1:0]  src_x,
    output logic [SRC_CW-1:0]  src_y,
    output logic               frame_start,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               vde,
    output logic               hSync,
    output logic               vSync
);

    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned WIN_W     = 2 * SRC_W;
    localparam int unsigned WIN_H     = 2 * SRC_H;
    localparam logic        SYNC_IDLE = (SYNC_ACT_HIGH == 0);

    // Refuse configurations the 10-bit counters or the pipeline cannot honour
    if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_total_chk
        $error("raster total exceeds 10-bit counter range");
    end
    if (PIX_LAT < 1 || PIX_LAT > 8) begin : g_lat_chk
        $error("PIX_LAT must be within 1..8");
    end
    if (WIN_X0 + WIN_W > H_ACTIVE || WIN_Y0 + WIN_H > V_ACTIVE) begin : g_win_chk
        $error("scaled window does not fit in the active area");
    end

    logic [CNT_W-1:0]  r_hcnt;
    logic [CNT_W-1:0]  r_vcnt;
    logic              w_hwrap;
    logic              w_vwrap;
    vflags_t           w_flags;
    logic [SRC_CW-1:0] w_src_x;
    logic [SRC_CW-1:0] w_src_y;

    logic              r_src_req;
    logic              r_frame_start;
    logic [SRC_CW-1:0] r_src_x;
    logic [SRC_CW-1:0] r_src_y;
    vflags_t           r_s_flags;
    vflags_t           w_d_flags;

    rgb_t              w_rgb;
    rgb_t              r_rgb;
    logic              r_vde;
    logic              r_hsync;
    logic              r_vsync;

    assign w_hwrap = (r_hcnt == CNT_W'(H_TOTAL - 1));
    assign w_vwrap = (r_vcnt == CNT_W'(V_TOTAL - 1));
    assign w_src_x = SRC_CW'((r_hcnt - CNT_W'(WIN_X0)) >> 1);
    assign w_src_y = SRC_CW'((r_vcnt - CNT_W'(WIN_Y0)) >> 1);

    // Raster position decode at the counter stage
    always_comb begin
        w_flags        = '0;
        w_flags.active = (32'(r_hcnt) < H_ACTIVE) && (32'(r_vcnt) < V_ACTIVE);
        w_flags.win    = in_range(r_hcnt, WIN_X0, WIN_W) && in_range(r_vcnt, WIN_Y0, WIN_H);
        w_flags.hs     = in_range(r_hcnt, H_ACTIVE + H_FP, H_SYNC);
        w_flags.vs     = in_range(r_vcnt, V_ACTIVE + V_FP, V_SYNC);
    end

    // Horizontal/vertical counters; both wrap together at the frame end
    always_ff @(posedge pixclk) begin
        if (!reset_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_hwrap) begin
            r_hcnt <= '0;
            r_vcnt <= w_vwrap ? '0 : r_vcnt + CNT_W'(1);
        end else begin
            r_hcnt <= r_hcnt + CNT_W'(1);
        end
    end

    // Fetch stage: request, halved source coordinates (held outside the window)
    always_ff @(posedge pixclk) begin
        if (!reset_n) begin
            r_src_req     <= 1'b0;
            r_frame_start <= 1'b0;
            r_src_x       <= '0;
            r_src_y       <= '0;
            r_s_flags     <= '0;
        end else begin
            r_src_req     <= w_flags.win;
            r_frame_start <= (r_hcnt == '0) && (r_vcnt == '0);
            r_s_flags     <= w_flags;
            if (w_flags.win) begin
                r_src_x <= w_src_x;
                r_src_y <= w_src_y;
            end
        end
    end

    // Flags wait out the source latency so they meet the returned colour
    video_timing_scaler_sig_delay #(
        .W (VFLAGS_W),
        .N (PIX_LAT)
    ) u_flag_delay (
        .pixclk  (pixclk),
        .reset_n (reset_n),
        .i_d     (r_s_flags),
        .o_q     (w_d_flags)
    );

    // Colour select: source inside the window, border elsewhere, black in blanking
    always_comb begin
        w_rgb = '0;
        if (w_d_flags.active) begin
            w_rgb = w_d_flags.win ? rgb_t'(src_rgb) : rgb_t'(border_rgb);
        end
    end

    // Output register stage, all pins mutually aligned
    always_ff @(posedge pixclk) begin
        if (!reset_n) begin
            r_rgb   <= '0;
            r_vde   <= 1'b0;
            r_hsync <= SYNC_IDLE;
            r_vsync <= SYNC_IDLE;
        end else begin
            r_rgb   <= w_rgb;
            r_vde   <= w_d_flags.active;
            r_hsync <= w_d_flags.hs ^ SYNC_IDLE;
            r_vsync <= w_d_flags.vs ^ SYNC_IDLE;
        end
    end

    assign src_req     = r_src_req;
    assign src_x       = r_src_x;
    assign src_y       = r_src_y;
    assign frame_start = r_frame_start;
    assign red         = r_rgb.r;
    assign green       = r_rgb.g;
    assign blue        = r_rgb.b;
    assign vde         = r_vde;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;

endmodule
